// File: rtl/gerador_bits_1_if.sv
// ============================================================================
// Module   : gerador_bits_1_if
// Purpose  : Request/serial-stream bundle for the thermometer bit generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gerador_bits_1_if #(
    parameter int LARGURA = 8,
    parameter int CW      = $clog2(LARGURA + 1)
);
    logic          inicio;
    logic [CW-1:0] quant_um;
    logic          pronto_rx;
    logic          saida_serial;
    logic          saida_valida;
    logic          ocupado;
    logic          fim;
    logic          erro;

    modport master (
        output inicio,
        output quant_um,
        output pronto_rx,
        input  saida_serial,
        input  saida_valida,
        input  ocupado,
        input  fim,
        input  erro
    );

    modport slave (
        input  inicio,
        input  quant_um,
        input  pronto_rx,
        output saida_serial,
        output saida_valida,
        output ocupado,
        output fim,
        output erro
    );
endinterface

`default_nettype wire

// File: rtl/gerador_bits_1.sv
// ============================================================================
// Module   : gerador_bits_1
// Purpose  : Serially emits a LARGURA-bit frame holding exactly quant_um ones,
//            LSB-first, ones first (thermometer order).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gerador_bits_1 #(
    parameter int LARGURA = 8,
    parameter int CW      = $clog2(LARGURA + 1)
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    gerador_bits_1_if.slave   bus
);

    localparam int            IW     = $clog2(LARGURA);
    localparam logic [CW-1:0] C_MAX  = CW'(LARGURA);
    localparam logic [IW-1:0] C_ULT  = IW'(LARGURA - 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ENVIANDO = 2'd1,
        FIM      = 2'd2
    } estado_t;

    estado_t       r_estado;
    estado_t       w_estado_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic [CW-1:0] r_n;
    logic [CW-1:0] w_n_nxt;
    logic          r_erro;
    logic          w_erro_nxt;
    logic          w_acima;

    assign w_acima = (bus.quant_um > C_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
            r_idx    <= '0;
            r_n      <= '0;
            r_erro   <= 1'b0;
        end else begin
            r_estado <= w_estado_nxt;
            r_idx    <= w_idx_nxt;
            r_n      <= w_n_nxt;
            r_erro   <= w_erro_nxt;
        end
    end

    always_comb begin
        w_estado_nxt = r_estado;
        w_idx_nxt    = r_idx;
        w_n_nxt      = r_n;
        w_erro_nxt   = r_erro;
        case (r_estado)
            OCIOSO: begin
                if (bus.inicio) begin
                    // Oversized requests saturate to a full frame and flag erro
                    w_n_nxt      = w_acima ? C_MAX : bus.quant_um;
                    w_erro_nxt   = w_acima;
                    w_idx_nxt    = '0;
                    w_estado_nxt = ENVIANDO;
                end
            end
            ENVIANDO: begin
                if (bus.pronto_rx) begin
                    if (r_idx == C_ULT) begin
                        w_estado_nxt = FIM;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            FIM: begin
                w_estado_nxt = OCIOSO;
            end
            default: begin
                w_estado_nxt = OCIOSO;
            end
        endcase
    end

    // Outputs decode registers only, so an async reset clears them at once
    assign bus.saida_valida = (r_estado == ENVIANDO);
    assign bus.saida_serial = (r_estado == ENVIANDO) && (CW'(r_idx) < r_n);
    assign bus.ocupado      = (r_estado != OCIOSO);
    assign bus.fim          = (r_estado == FIM);
    assign bus.erro         = r_erro;

endmodule

`default_nettype wire

// File: tb/tb_gerador_bits_1.sv
// ============================================================================
// Module   : tb_gerador_bits_1
// Purpose  : Directed self-checking bench for gerador_bits_1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gerador_bits_1;

    localparam int LARGURA = 8;
    localparam int CW      = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gerador_bits_1_if #(.LARGURA(LARGURA), .CW(CW)) bus ();

    gerador_bits_1 #(.LARGURA(LARGURA), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at an idle negedge, ends at the idle negedge after fim
    task automatic frame(input logic [CW-1:0] q, input logic [7:0] exp_bits,
                         input logic exp_erro, input logic inicio_em_fim,
                         output int t_first);
        int pc;
        pc = 0;
        bus.quant_um  = q;
        bus.inicio    = 1'b1;
        bus.pronto_rx = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        t_first    = cyc;
        for (int i = 0; i < LARGURA; i++) begin
            chk($sformatf("valida q=%0d b%0d", q, i), bus.saida_valida, 1);
            chk($sformatf("bit q=%0d b%0d", q, i), bus.saida_serial, exp_bits[i]);
            if (i == 0) begin
                chk($sformatf("erro q=%0d", q), bus.erro, exp_erro);
                chk($sformatf("ocupado q=%0d", q), bus.ocupado, 1);
                chk($sformatf("fim_cedo q=%0d", q), bus.fim, 0);
            end
            pc += int'(bus.saida_serial);
            @(negedge clk);
        end
        chk($sformatf("fim q=%0d", q), bus.fim, 1);
        chk($sformatf("valida_fim q=%0d", q), bus.saida_valida, 0);
        chk($sformatf("ocupado_fim q=%0d", q), bus.ocupado, 1);
        chk($sformatf("popcount q=%0d", q), pc, $countones(exp_bits));
        if (inicio_em_fim) bus.inicio = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        chk($sformatf("ocioso q=%0d", q), bus.ocupado, 0);
        chk($sformatf("fim_pos q=%0d", q), bus.fim, 0);
        chk($sformatf("erro_pos q=%0d", q), bus.erro, exp_erro);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ta, tb2, tx;
        int         pc, nfim, nocup, xfer, t_last, t_fim;
        logic       prev_stall, prev_bit;
        logic [7:0] got;
        logic [19:0] pat;

        rst_n         = 1'b0;
        bus.inicio    = 1'b0;
        bus.quant_um  = '0;
        bus.pronto_rx = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst valida",  bus.saida_valida, 0);
        chk("rst serial",  bus.saida_serial, 0);
        chk("rst ocupado", bus.ocupado, 0);
        chk("rst fim",     bus.fim, 0);
        chk("rst erro",    bus.erro, 0);
        rst_n = 1'b1;
        @(negedge clk);

        frame(4'd3, 8'b0000_0111, 1'b0, 1'b0, tx);

        // Back-to-back; inicio during FIM of the second frame must be ignored
        frame(4'd0, 8'h00, 1'b0, 1'b0, ta);
        frame(4'd8, 8'hFF, 1'b0, 1'b1, tb2);
        chk("periodo", tb2 - ta, LARGURA + 2);

        frame(4'd12, 8'hFF, 1'b1, 1'b0, tx);
        frame(4'd2, 8'b0000_0011, 1'b0, 1'b0, tx);

        // Backpressure
        pat        = 20'hFCDA9;
        bus.quant_um  = 4'd5;
        bus.inicio    = 1'b1;
        bus.pronto_rx = 1'b0;
        @(negedge clk);
        bus.inicio = 1'b0;
        prev_stall = 1'b0;
        prev_bit   = 1'b0;
        xfer = 0; nfim = 0; t_last = -1; t_fim = -1; got = '0;
        for (int c = 0; c < 30; c++) begin
            if (prev_stall) chk($sformatf("estavel c%0d", c), bus.saida_serial, prev_bit);
            if (bus.fim) begin
                nfim++;
                t_fim = cyc;
            end
            bus.pronto_rx = (c < 20) ? pat[c] : 1'b1;
            prev_stall    = bus.saida_valida && !bus.pronto_rx;
            prev_bit      = bus.saida_serial;
            if (bus.saida_valida && bus.pronto_rx) begin
                if (xfer < 8) got[xfer] = bus.saida_serial;
                xfer++;
                t_last = cyc;
            end
            @(negedge clk);
        end
        chk("stall xfers",  xfer, 8);
        chk("stall bits",   got, 8'h1F);
        chk("stall nfim",   nfim, 1);
        chk("stall t_fim",  t_fim, t_last + 1);

        // Mid-frame request must not disturb the running frame
        bus.quant_um  = 4'd5;
        bus.inicio    = 1'b1;
        bus.pronto_rx = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        pc = 0; nfim = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 2) begin
                bus.quant_um = 4'd1;
                bus.inicio   = 1'b1;
            end
            if (c == 5) bus.inicio = 1'b0;
            if (bus.saida_valida) pc += int'(bus.saida_serial);
            if (bus.fim) nfim++;
            @(negedge clk);
        end
        chk("ignora pop",  pc, 5);
        chk("ignora nfim", nfim, 1);
        chk("ignora idle", bus.ocupado, 0);

        // Asynchronous reset three bits into a frame
        frame(4'd12, 8'hFF, 1'b1, 1'b0, tx);
        bus.quant_um  = 4'd5;
        bus.inicio    = 1'b1;
        bus.pronto_rx = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst ocupado", bus.ocupado, 1);
        chk("pre_rst erro",    bus.erro, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst valida",  bus.saida_valida, 0);
        chk("arst serial",  bus.saida_serial, 0);
        chk("arst ocupado", bus.ocupado, 0);
        chk("arst fim",     bus.fim, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nfim = 0; nocup = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.fim) nfim++;
            if (bus.ocupado) nocup++;
            @(negedge clk);
        end
        chk("pos_rst nfim",    nfim, 0);
        chk("pos_rst ocupado", nocup, 0);
        frame(4'd3, 8'b0000_0111, 1'b0, 1'b0, tx);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
